// File: rtl/us_ctrl.sv
// Upsampler front-end controller: takes mapped I/Q symbols through a one-entry buffer and
// presents each symbol to the upsamplers for UP_FACTOR cycles, then flushes with zeros.
module us_ctrl #(
   parameter int FRAME_LEN = 512,
   parameter int UP_FACTOR = 4,
   parameter int DRAIN_CYC = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       i_valid,
   input  logic [1:0] i_data,
   input  logic [1:0] q_data,
   output logic       i_ready,
   output logic       us_en,
   output logic [1:0] us_din_i,
   output logic [1:0] us_din_q,
   output logic [2:0] phase,
   output logic [9:0] sym_cnt,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam logic [2:0] LAST_PHASE = 3'(UP_FACTOR - 1);
   localparam logic [9:0] LAST_SYM   = 10'(FRAME_LEN);
   localparam logic [7:0] LAST_DRAIN = 8'(DRAIN_CYC);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

   state_t     state;
   logic       buf_valid;
   logic [1:0] buf_i;
   logic [1:0] buf_q;
   logic [9:0] acc_cnt;
   logic [7:0] drain_cnt;
   logic       accept;

   // NOTE: i_ready is decoded from registered state only, so it never depends on i_valid
   // and cannot form a combinational loop with the mapper's handshake logic.
   assign i_ready = ((state == LOAD) || (state == RUN)) && !buf_valid && (acc_cnt < LAST_SYM);
   assign accept  = i_valid && i_ready;

   // NOTE: every register here, including the buffer data, is in the async reset so that
   // all outputs read zero the moment reset rises, with no clock required.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         buf_valid <= 1'b0;
         buf_i     <= '0;
         buf_q     <= '0;
         acc_cnt   <= '0;
         drain_cnt <= '0;
         us_en     <= 1'b0;
         us_din_i  <= '0;
         us_din_q  <= '0;
         phase     <= '0;
         sym_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment in this block to
         // the same register deliberately overrides an earlier one in the same cycle.
         done <= 1'b0;

         // A consume only clears a full buffer, and accept needs an empty one, so the two
         // never collide on buf_valid.
         if (accept) begin
            buf_i     <= i_data;
            buf_q     <= q_data;
            buf_valid <= 1'b1;
            acc_cnt   <= acc_cnt + 10'd1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  busy      <= 1'b1;
                  sym_cnt   <= '0;
                  acc_cnt   <= '0;
                  underrun  <= 1'b0;
                  buf_valid <= 1'b0;
               end
            end
            LOAD: begin
               if (buf_valid) begin
                  state     <= RUN;
                  us_en     <= 1'b1;
                  us_din_i  <= buf_i;
                  us_din_q  <= buf_q;
                  buf_valid <= 1'b0;
                  phase     <= '0;
                  sym_cnt   <= 10'd1;
               end
            end
            RUN: begin
               if (phase == LAST_PHASE) begin
                  phase <= '0;
                  if (sym_cnt == LAST_SYM) begin
                     state     <= DRAIN;
                     us_din_i  <= '0;
                     us_din_q  <= '0;
                     drain_cnt <= 8'd1;
                  end else begin
                     sym_cnt <= sym_cnt + 10'd1;
                     if (buf_valid) begin
                        us_din_i  <= buf_i;
                        us_din_q  <= buf_q;
                        buf_valid <= 1'b0;
                     end else begin
                        // Starved: insert a zero symbol rather than stretch frame timing.
                        us_din_i <= '0;
                        us_din_q <= '0;
                        underrun <= 1'b1;
                     end
                  end
               end else begin
                  phase <= phase + 3'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt == LAST_DRAIN) begin
                  state <= DONE;
                  us_en <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_us_ctrl.sv
// Self-checking bench for us_ctrl: a default-sized instance for frame, underrun, backpressure
// and reset scenarios, plus a FRAME_LEN=1 instance for the single-symbol corner case.
module tb_us_ctrl;

   localparam int FL = 512;
   localparam int UF = 4;
   localparam int DC = 8;
   localparam int EN_LEN = FL * UF + DC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b0;
   logic       start, i_valid, i_ready, us_en, busy, done, underrun;
   logic [1:0] i_data, q_data, us_din_i, us_din_q;
   logic [2:0] phase;
   logic [9:0] sym_cnt;

   logic       start_s, valid_s, ready_s, us_en_s, busy_s, done_s, underrun_s;
   logic [1:0] i_data_s, q_data_s, din_i_s, din_q_s;
   logic [2:0] phase_s;
   logic [9:0] sym_cnt_s;

   us_ctrl #(.FRAME_LEN(FL), .UP_FACTOR(UF), .DRAIN_CYC(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .i_valid(i_valid), .i_data(i_data),
      .q_data(q_data), .i_ready(i_ready), .us_en(us_en), .us_din_i(us_din_i),
      .us_din_q(us_din_q), .phase(phase), .sym_cnt(sym_cnt), .busy(busy), .done(done),
      .underrun(underrun));

   us_ctrl #(.FRAME_LEN(1), .UP_FACTOR(4), .DRAIN_CYC(8)) dut_short (
      .clk(clk), .reset(reset), .start(start_s), .i_valid(valid_s), .i_data(i_data_s),
      .q_data(q_data_s), .i_ready(ready_s), .us_en(us_en_s), .us_din_i(din_i_s),
      .us_din_q(din_q_s), .phase(phase_s), .sym_cnt(sym_cnt_s), .busy(busy_s), .done(done_s),
      .underrun(underrun_s));

   int tests = 0;
   int fails = 0;

   // Monitor state for the default instance, rebuilt for every frame.
   logic [3:0] acc_q[$];
   logic [3:0] out_q[$];
   int cyc, hs_cnt, hs_last_cyc, hs_gap_err, ready_late;
   int en_cnt, en_runs, last_en_cyc, done_cnt, done_cyc, track_err;
   int gap_after, gap_left;
   bit prev_en, want_valid;
   int hold_err, data_err, zero_syms;

   function automatic logic [3:0] rand_sym();
      logic [3:0] v;
      do v = 4'($urandom_range(0, 15)); while (v == 4'd0);
      return v;
   endfunction

   task automatic new_sym();
      logic [3:0] v;
      v = rand_sym();
      i_data = v[3:2];
      q_data = v[1:0];
   endtask

   task automatic clear_mon();
      acc_q.delete();
      out_q.delete();
      cyc = 0; hs_cnt = 0; hs_last_cyc = 0; hs_gap_err = 0; ready_late = 0;
      en_cnt = 0; en_runs = 0; last_en_cyc = -10; done_cnt = 0; done_cyc = -1;
      track_err = 0; gap_after = 0; gap_left = 0; prev_en = 1'b0;
   endtask

   // One clock: sample at the falling edge, then update stimulus just after the rising edge.
   task automatic cycle();
      bit hs;
      @(negedge clk);
      cyc++;
      hs = i_valid && i_ready;
      if (i_ready && hs_cnt >= FL) ready_late++;
      if (hs) begin
         if (hs_cnt >= 2 && hs_cnt < FL - 1 && cyc - hs_last_cyc != UF) hs_gap_err++;
         hs_last_cyc = cyc;
         hs_cnt++;
         acc_q.push_back({i_data, q_data});
      end
      if (us_en) begin
         en_cnt++;
         last_en_cyc = cyc;
         if (!prev_en) en_runs++;
         out_q.push_back({us_din_i, us_din_q});
         // Symbol index and phase follow directly from how long us_en has been high.
         if (en_cnt <= FL * UF) begin
            if (sym_cnt != 10'((en_cnt + UF - 1) / UF) || phase != 3'((en_cnt - 1) % UF))
               track_err++;
         end else if (sym_cnt != 10'(FL) || phase != 3'd0) track_err++;
      end
      prev_en = us_en;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (hs) new_sym();
      if (gap_after != 0 && hs && hs_cnt == gap_after) gap_left = 10;
      if (gap_left > 0) begin
         i_valid = 1'b0;
         gap_left--;
      end else i_valid = want_valid;
   endtask

   task automatic start_frame();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_done(output bit timed_out);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         cycle();
         n++;
      end
      timed_out = (done_cnt == 0);
      repeat (4) cycle();
   endtask

   // Splits the captured us_din stream into symbols and matches them against accepted input;
   // zero symbols are insertions because the stimulus never sends 0/0.
   task automatic analyze();
      int n;
      logic [3:0] s;
      hold_err = 0; data_err = 0; zero_syms = 0; n = 0;
      if (out_q.size() != EN_LEN) begin
         data_err = 1;
         hold_err = 1;
         return;
      end
      for (int k = 0; k < FL; k++) begin
         s = out_q[k * UF];
         for (int j = 1; j < UF; j++) if (out_q[k * UF + j] != s) hold_err++;
         if (s == 4'd0) zero_syms++;
         else begin
            if (n >= acc_q.size() || s != acc_q[n]) data_err++;
            n++;
         end
      end
      for (int j = FL * UF; j < EN_LEN; j++) if (out_q[j] != 4'd0) hold_err++;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      tests++; if ({i_ready, us_en, us_din_i, us_din_q, phase, sym_cnt, busy, done, underrun} !== 23'd0) begin fails++; $display("FAIL reset_async: got %h expected 0", {i_ready, us_en, us_din_i, us_din_q, phase, sym_cnt, busy, done, underrun}); end
      tests++; if ({ready_s, us_en_s, din_i_s, din_q_s, phase_s, sym_cnt_s, busy_s, done_s, underrun_s} !== 23'd0) begin fails++; $display("FAIL reset_async_short: got %h expected 0", {ready_s, us_en_s, din_i_s, din_q_s, phase_s, sym_cnt_s, busy_s, done_s, underrun_s}); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      tests++; if ({i_ready, busy, us_en, done} !== 4'd0) begin fails++; $display("FAIL reset_idle: got %b expected 0000", {i_ready, busy, us_en, done}); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_hold();
      int bad, n;
      bit to;
      clear_mon();
      want_valid = 1'b0;
      i_valid = 1'b0;
      new_sym();
      start_frame();
      bad = 0;
      repeat (20) begin
         cycle();
         if (us_en !== 1'b0 || busy !== 1'b1 || i_ready !== 1'b1) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL load_hold: got %0d bad cycles expected 0", bad); end
      want_valid = 1'b1;
      i_valid = 1'b1;
      n = 0;
      while (en_cnt < 40 && n < 200) begin
         cycle();
         n++;
      end
      start = 1'b1;
      cycle();
      start = 1'b0;
      wait_done(to);
      tests++; if (to) begin fails++; $display("FAIL lh_timeout: got no done expected done"); end
      tests++; if (en_cnt != EN_LEN) begin fails++; $display("FAIL lh_en_len: got %0d expected %0d", en_cnt, EN_LEN); end
      tests++; if (en_runs != 1) begin fails++; $display("FAIL lh_en_runs: got %0d expected 1", en_runs); end
      tests++; if (track_err != 0) begin fails++; $display("FAIL lh_start_ignored: got %0d tracking errors expected 0", track_err); end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL lh_done_cnt: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_underrun();
      bit to;
      clear_mon();
      want_valid = 1'b1;
      i_valid = 1'b1;
      gap_after = 3;
      new_sym();
      start_frame();
      wait_done(to);
      analyze();
      tests++; if (to) begin fails++; $display("FAIL ur_timeout: got no done expected done"); end
      tests++; if (en_cnt != EN_LEN || en_runs != 1) begin fails++; $display("FAIL ur_en_len: got %0d in %0d runs expected %0d in 1", en_cnt, en_runs, EN_LEN); end
      tests++; if (zero_syms < 1) begin fails++; $display("FAIL ur_zero_insert: got %0d expected >=1", zero_syms); end
      tests++; if (data_err != 0 || hold_err != 0) begin fails++; $display("FAIL ur_data: got %0d/%0d errors expected 0/0", data_err, hold_err); end
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_flag: got %b expected 1", underrun); end
      tests++; if (sym_cnt !== 10'(FL)) begin fails++; $display("FAIL ur_sym_cnt: got %0d expected %0d", sym_cnt, FL); end
      tests++; if (track_err != 0 || done_cnt != 1) begin fails++; $display("FAIL ur_track: got %0d errors, %0d done expected 0, 1", track_err, done_cnt); end
   endtask

   task automatic test_full_frame(input string tag);
      bit to;
      clear_mon();
      want_valid = 1'b1;
      i_valid = 1'b1;
      new_sym();
      start_frame();
      wait_done(to);
      analyze();
      tests++; if (to) begin fails++; $display("FAIL %s_timeout: got no done expected done", tag); end
      tests++; if (en_cnt != EN_LEN || en_runs != 1) begin fails++; $display("FAIL %s_en_len: got %0d in %0d runs expected %0d in 1", tag, en_cnt, en_runs, EN_LEN); end
      tests++; if (data_err != 0 || zero_syms != 0 || hold_err != 0) begin fails++; $display("FAIL %s_data: got %0d/%0d/%0d errors expected 0/0/0", tag, data_err, zero_syms, hold_err); end
      tests++; if (track_err != 0) begin fails++; $display("FAIL %s_sym_phase: got %0d errors expected 0", tag, track_err); end
      tests++; if (done_cnt != 1 || done_cyc != last_en_cyc + 1) begin fails++; $display("FAIL %s_done: got %0d pulses at %0d expected 1 at %0d", tag, done_cnt, done_cyc, last_en_cyc + 1); end
      tests++; if (hs_cnt != FL) begin fails++; $display("FAIL %s_handshakes: got %0d expected %0d", tag, hs_cnt, FL); end
      tests++; if (hs_gap_err != 0) begin fails++; $display("FAIL %s_ready_rate: got %0d irregular gaps expected 0", tag, hs_gap_err); end
      tests++; if (ready_late != 0) begin fails++; $display("FAIL %s_ready_after_last: got %0d cycles expected 0", tag, ready_late); end
      tests++; if (underrun !== 1'b0 || sym_cnt !== 10'(FL)) begin fails++; $display("FAIL %s_status: got underrun=%b sym_cnt=%0d expected 0, %0d", tag, underrun, sym_cnt, FL); end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      clear_mon();
      want_valid = 1'b1;
      i_valid = 1'b1;
      new_sym();
      start_frame();
      n = 0;
      while (sym_cnt != 10'd100 && n < 1000) begin
         cycle();
         n++;
      end
      tests++; if (sym_cnt !== 10'd100) begin fails++; $display("FAIL rm_reach_100: got %0d expected 100", sym_cnt); end
      #2 reset = 1'b1;
      #1;
      tests++; if ({i_ready, us_en, us_din_i, us_din_q, phase, sym_cnt, busy, done, underrun} !== 23'd0) begin fails++; $display("FAIL rm_outputs: got %h expected 0", {i_ready, us_en, us_din_i, us_din_q, phase, sym_cnt, busy, done, underrun}); end
      repeat (3) cycle();
      reset = 1'b0;
      repeat (3) cycle();
      tests++; if (done_cnt != 0) begin fails++; $display("FAIL rm_no_done: got %0d pulses expected 0", done_cnt); end
      tests++; if (busy !== 1'b0 || i_ready !== 1'b0) begin fails++; $display("FAIL rm_idle: got busy=%b ready=%b expected 0, 0", busy, i_ready); end
   endtask

   task automatic test_short_frame();
      int en, runs, dn, dcyc, lcyc, hs, c, bad;
      logic [3:0] acc, v;
      logic [3:0] outs[$];
      bit pe;
      en = 0; runs = 0; dn = 0; dcyc = -1; lcyc = -10; hs = 0; c = 0; bad = 0;
      acc = '0; pe = 1'b0;
      v = rand_sym();
      i_data_s = v[3:2];
      q_data_s = v[1:0];
      valid_s = 1'b1;
      start_s = 1'b1;
      while (c < 60) begin
         @(negedge clk);
         c++;
         if (valid_s && ready_s) begin
            hs++;
            acc = {i_data_s, q_data_s};
         end
         if (us_en_s) begin
            en++;
            lcyc = c;
            if (!pe) runs++;
            outs.push_back({din_i_s, din_q_s});
         end
         pe = us_en_s;
         if (done_s) begin
            dn++;
            dcyc = c;
         end
         @(posedge clk);
         #1;
         start_s = 1'b0;
      end
      if (outs.size() == 12) begin
         for (int j = 0; j < 4; j++) if (outs[j] != acc) bad++;
         for (int j = 4; j < 12; j++) if (outs[j] != 4'd0) bad++;
      end else bad = 1;
      tests++; if (en != 12 || runs != 1) begin fails++; $display("FAIL sf_en_len: got %0d in %0d runs expected 12 in 1", en, runs); end
      tests++; if (hs != 1) begin fails++; $display("FAIL sf_handshakes: got %0d expected 1", hs); end
      tests++; if (bad != 0) begin fails++; $display("FAIL sf_data: got %0d errors expected 0", bad); end
      tests++; if (dn != 1 || dcyc != lcyc + 1) begin fails++; $display("FAIL sf_done: got %0d pulses at %0d expected 1 at %0d", dn, dcyc, lcyc + 1); end
      tests++; if (sym_cnt_s !== 10'd1 || underrun_s !== 1'b0) begin fails++; $display("FAIL sf_status: got sym_cnt=%0d underrun=%b expected 1, 0", sym_cnt_s, underrun_s); end
   endtask

   initial begin
      start = 1'b0; i_valid = 1'b0; i_data = '0; q_data = '0; want_valid = 1'b0;
      start_s = 1'b0; valid_s = 1'b0; i_data_s = '0; q_data_s = '0;
      clear_mon();
      test_reset();
      test_load_hold();
      test_underrun();
      test_full_frame("ff");
      test_reset_mid_frame();
      test_full_frame("after_reset");
      test_short_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/us_ctrl.md
US_CTRL -- requirements
Module: us_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 512: symbols emitted per frame, range 1..1023.
REQ-002 Parameter UP_FACTOR, default 4: output cycles per symbol, power of two, range 2..8.
REQ-003 Parameter DRAIN_CYC, default 8: zero-data flush cycles after the last symbol, range 1..255.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  frame start request; sampled in IDLE only.
REQ-007 i_valid  in  1  mapper symbol valid.
REQ-008 i_data, q_data  in  2 each  mapped I/Q symbol.
REQ-009 i_ready  out  1  symbol accepted on a clk edge where i_valid and i_ready are both high.
REQ-010 us_en  out  1  enable to both upsamplers.
REQ-011 us_din_i, us_din_q  out  2 each  upsampler data inputs.
REQ-012 phase  out  3  position within the current symbol, 0..UP_FACTOR-1.
REQ-013 sym_cnt  out  10  symbols emitted in the current frame.
REQ-014 busy  out  1; done  out  1; underrun  out  1 (sticky).

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, DRAIN and DONE; busy=1 in LOAD, RUN and DRAIN.
REQ-016 IDLE: start=1 -> LOAD; clear sym_cnt, accepted count, underrun and buffer; start in any other state is ignored.
REQ-017 The symbol buffer is one entry; i_ready=1 iff state is LOAD or RUN, buffer empty, and accepted count < FRAME_LEN.
REQ-018 A symbol is accepted only on an i_valid and i_ready handshake; the symbol is written to the buffer and the accepted count increments.
REQ-019 LOAD with buffer full -> RUN: buffer moves to us_din_i/q, buffer empties, phase=0, us_en=1, sym_cnt=1.
REQ-020 LOAD with buffer empty: hold in LOAD with us_en=0, and do not count cycles.
REQ-021 RUN: phase increments every cycle and wraps at UP_FACTOR-1; us_din_i/q are held for the full UP_FACTOR cycles.
REQ-022 RUN at phase=UP_FACTOR-1 and sym_cnt=FRAME_LEN: -> DRAIN, us_din_i/q=0, phase=0.
REQ-023 RUN at phase=UP_FACTOR-1 with buffer full: load the next symbol and sym_cnt+1.
REQ-024 RUN at phase=UP_FACTOR-1 with buffer empty: load 0/0, sym_cnt+1 and underrun=1. Frame timing is never stretched.
REQ-025 Accept and consume never coincide on the buffer (enforced by REQ-017); an accept in the cycle after a consume is legal.
REQ-026 DRAIN: us_en=1 and data=0 for exactly DRAIN_CYC cycles, then -> DONE with us_en=0.
REQ-027 DONE: done=1 for exactly one cycle, then -> IDLE; sym_cnt and underrun hold their values until the next start.
REQ-028 us_en SHALL be high for exactly FRAME_LEN*UP_FACTOR+DRAIN_CYC consecutive cycles per frame when LOAD exits on the first symbol.
REQ-029 All outputs SHALL be registered, except i_ready, which is decoded from registered state.

Reset
REQ-030 While reset=1, all of the following SHALL be 0 immediately, independent of clk: state=IDLE, us_en, us_din_i/q, phase, sym_cnt, busy, done, underrun, i_ready, buffer valid and accepted count.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first start after release begins a clean frame.

Verification
REQ-032 Reset in RUN at sym_cnt=100 -> all outputs 0 within the same cycle; no done pulse; a new start runs a full 512-symbol frame.
REQ-033 FRAME_LEN=512 with i_valid always high and random data:
- us_din_i/q equal the input sequence, each value held 4 cycles;
- us_en high 2056 cycles;
- underrun=0, sym_cnt=512;
- done pulses once, one cycle after us_en falls.
REQ-034 i_valid low for 10 cycles after symbol 3 is accepted -> at least one 0/0 symbol is inserted, underrun=1, sym_cnt still reaches 512, and us_en duration is unchanged.
REQ-035 Backpressure with i_valid stuck high:
- i_ready pulses once per 4 cycles in steady state;
- exactly 512 handshakes occur;
- i_ready=0 after the 512th handshake.
REQ-036 Start with i_valid low -> FSM stays in LOAD with us_en=0 for 20 cycles; a pulse on start during RUN has no effect.
REQ-037 FRAME_LEN=1, UP_FACTOR=4, DRAIN_CYC=8 -> us_en high 12 cycles, one symbol held 4 cycles, then done=1 for one cycle.
